aes_v2_arb: RTL and testbench
=============================

Name: aes_v2_arb

Overview:
Round-robin arbiter and sequencer that shares one size-optimised 4-cycle AES SubBytes/MixColumns unit between NREQ requesters, e.g. two harts or two issue slots. It accepts one request per grant and captures the request's operands. It holds those operands stable for the unit's whole multi-cycle operation, then returns the registered result to the owning requester. It also detects unit protocol errors and timeouts.

Parameters:
NREQ, 2, number of requesters (2..4).
TIMEOUT, 15, maximum BUSY cycles without aes_ready before the operation is abandoned (>=4).

Ports:
g_clk  in  1  clock.
g_resetn  in  1  reset, synchronous, active-low.
req_valid  in  NREQ  per-requester request; held until req_ack.
req_sub  in  NREQ  1 = SubBytes, 0 = MixColumns.
req_enc  in  NREQ  1 = encrypt, 0 = decrypt.
req_rs1  in  32*NREQ  operand 1; requester i uses bits [32i+31:32i].
req_rs2  in  32*NREQ  operand 2, same packing.
req_ack  out  NREQ  one-hot, one-cycle grant pulse; the requester may drop or change its inputs after it.
resp_valid  out  NREQ  one-hot, one-cycle result pulse to the owning requester.
resp_rd  out  32  result; valid only while resp_valid is nonzero.
busy  out  1  unit is owned by a requester.
err  out  1  sticky; set on protocol error or timeout.
aes_valid  out  1  to unit: start.
aes_sub  out  1  to unit.
aes_enc  out  1  to unit.
aes_rs1  out  32  to unit.
aes_rs2  out  32  to unit.
aes_ready  in  1  from unit: result on aes_rd this cycle.
aes_rd  in  32  from unit.

Behaviour:
- Reset values: req_ack=0, resp_valid=0, resp_rd=0, busy=0, err=0, aes_valid=0, FSM=IDLE. The round-robin pointer resets to NREQ-1, so requester 0 has first priority.
- The unit shares g_resetn. A reset mid-operation drops the operation and issues no resp_valid.
- IDLE state:
  - If any req_valid is set, the picker grants the first set bit searching upward from pointer+1 (mod NREQ).
  - In the grant cycle: req_ack[g]=1 and aes_valid=1. aes_sub, aes_enc, aes_rs1 and aes_rs2 are driven combinationally from requester g.
  - On the same clock edge: capture g's operands into the op registers, owner<=g, pointer<=g, clear the timeout counter, go to BUSY.
- BUSY state:
  - aes_valid=0. Unit operands are driven from the op registers.
  - The unit samples rs1/rs2 on every one of its cycles, so the op registers change only in IDLE.
  - When aes_ready=1: resp_rd<=aes_rd, resp_valid[owner]<=1 on the next cycle, go to IDLE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT: err<=1, go to IDLE, no response.
- Latency: grant at cycle T, aes_ready at T+3, resp_valid at T+4. The next grant can occur at T+4, giving a sustained throughput of one operation per 4 cycles.
- No grant is issued while BUSY. req_valid is ignored in BUSY; no queueing.
- Protocol error: aes_ready=1 while IDLE sets err. It causes no other effect.
- A request whose req_valid drops before its ack is simply not granted. Dropping is legal but discouraged.
- Simultaneous requests are ordered strictly by the round-robin rule. The same requester never wins twice in a row while another is waiting.
- busy equals (FSM==BUSY). err clears only on reset.

Decomposition:
- Shared package aes_v2_pkg: FSM encodings (IDLE=1'b0, BUSY=1'b1), the NREQ maximum of 4, and the unit latency constant 4.
- One sub-module aes_rr_pick. It is purely combinational: req vector and pointer in, one-hot grant and index out.
- All state lives in aes_v2_arb: FSM, owner, pointer, op registers, timeout counter, and response register.

Test Plan:
- Single SubBytes request: req0, sub=1, enc=1, rs1=rs2=0x00000000 at T -> req_ack[0] at T, resp_valid[0] at T+4, resp_rd=0x63636363.
- Inverse SubBytes: req1, sub=1, enc=0, rs1=rs2=0x63636363 -> resp_valid[1] after 4 cycles, resp_rd=0x00000000. Then MixColumns: sub=0, enc=1, rs1=rs2=0x01010101 -> 0x01010101.
- Contention: req0 and req1 held continuously after reset -> grants alternate 0,1,0,1 at T, T+4, T+8, T+12. Each result goes to the correct owner, and its operands are unaffected by the other requester changing rs1 mid-operation.
- Operand hold: requester 0 drops req_valid and randomises rs1/rs2 the cycle after its ack -> result is still computed from the captured operands (0x63636363 case).
- Timeout: stub unit never asserts aes_ready -> err=1 after TIMEOUT=15 BUSY cycles, FSM returns to IDLE, no resp_valid, and the next request is granted normally.
- Reset mid-operation: g_resetn low at T+2 -> no resp_valid, busy=0, err=0. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/aes_v2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_v2_pkg
//  Description : Shared types and constants for the AES unit arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_v2_pkg;

    // Arbiter FSM: IDLE accepts a grant, BUSY owns the shared unit.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Largest supported requester count.
    localparam int NREQ_MAX     = 4;

    // Cycles from start (grant) to the response pulse.
    localparam int UNIT_LATENCY = 4;

    // Width of a requester index; at least one bit so NREQ=1 would still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : aes_rr_pick
//  Description : Combinational round-robin picker. Searches upward from
//                ptr+1 (mod NREQ) and returns the first requesting index,
//                both as a one-hot vector and as a binary index.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_rr_pick
    import aes_v2_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // First set request after the pointer wins; the pointer itself is checked last.
    always_comb begin
        int w_cand;
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = (int'(ptr) + k) % NREQ;
            if (!any && req[w_cand]) begin
                any           = 1'b1;
                grant[w_cand] = 1'b1;
                idx           = IW'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_v2_arb.sv
`default_nettype none
// ============================================================================
//  Module      : aes_v2_arb
//  Description : Round-robin arbiter/sequencer sharing one multi-cycle AES
//                SubBytes/MixColumns unit between NREQ requesters. Captures
//                the granted operands, holds them for the whole operation,
//                returns the result to the owner, flags protocol errors and
//                timeouts in a sticky err bit.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_v2_arb
    import aes_v2_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_sub,
    input  logic [NREQ-1:0]    req_enc,
    input  logic [32*NREQ-1:0] req_rs1,
    input  logic [32*NREQ-1:0] req_rs2,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    resp_valid,
    output logic [31:0]        resp_rd,
    output logic               busy,
    output logic               err,
    output logic               aes_valid,
    output logic               aes_sub,
    output logic               aes_enc,
    output logic [31:0]        aes_rs1,
    output logic [31:0]        aes_rs2,
    input  logic               aes_ready,
    input  logic [31:0]        aes_rd
);

    localparam int             IW  = idx_width(NREQ);
    localparam int             CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO = CW'(TIMEOUT);

    arb_state_t       r_state;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_ptr;
    logic             r_op_sub;
    logic             r_op_enc;
    logic [31:0]      r_op_rs1;
    logic [31:0]      r_op_rs2;
    logic [CW-1:0]    r_tcnt;

    logic [NREQ-1:0]  w_pick_grant;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic             w_grant_fire;
    logic             w_sel_sub;
    logic             w_sel_enc;
    logic [31:0]      w_sel_rs1;
    logic [31:0]      w_sel_rs2;
    logic [CW-1:0]    w_tcnt_next;

    aes_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_pick_grant),
        .idx   (w_pick_idx),
        .any   (w_pick_any)
    );

    // A grant only happens out of reset while the unit is free.
    assign w_grant_fire = g_resetn && (r_state == IDLE) && w_pick_any;
    assign req_ack      = w_grant_fire ? w_pick_grant : '0;
    assign aes_valid    = w_grant_fire;
    assign busy         = (r_state == BUSY);
    assign w_tcnt_next  = r_tcnt + 1'b1;

    // Fields of the requester currently being picked.
    always_comb begin
        w_sel_sub = req_sub[w_pick_idx];
        w_sel_enc = req_enc[w_pick_idx];
        w_sel_rs1 = req_rs1[32*int'(w_pick_idx) +: 32];
        w_sel_rs2 = req_rs2[32*int'(w_pick_idx) +: 32];
    end

    // Unit operands: straight from the picked requester in the start cycle,
    // from the captured copy for the rest of the operation.
    always_comb begin
        if (r_state == IDLE) begin
            aes_sub = w_sel_sub;
            aes_enc = w_sel_enc;
            aes_rs1 = w_sel_rs1;
            aes_rs2 = w_sel_rs2;
        end else begin
            aes_sub = r_op_sub;
            aes_enc = r_op_enc;
            aes_rs1 = r_op_rs1;
            aes_rs2 = r_op_rs2;
        end
    end

    // Arbiter FSM with operand capture, timeout counter and registered response.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_ptr      <= IW'(NREQ - 1);
            r_op_sub   <= 1'b0;
            r_op_enc   <= 1'b0;
            r_op_rs1   <= '0;
            r_op_rs2   <= '0;
            r_tcnt     <= '0;
            resp_valid <= '0;
            resp_rd    <= '0;
            err        <= 1'b0;
        end else begin
            resp_valid <= '0;
            case (r_state)
                IDLE: begin
                    // A result with no operation in flight is a unit protocol error.
                    if (aes_ready) begin
                        err <= 1'b1;
                    end
                    if (w_pick_any) begin
                        r_op_sub <= w_sel_sub;
                        r_op_enc <= w_sel_enc;
                        r_op_rs1 <= w_sel_rs1;
                        r_op_rs2 <= w_sel_rs2;
                        r_owner  <= w_pick_idx;
                        r_ptr    <= w_pick_idx;
                        r_tcnt   <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (aes_ready) begin
                        resp_rd    <= aes_rd;
                        resp_valid <= NREQ'(1) << r_owner;
                        r_state    <= IDLE;
                    end else if (w_tcnt_next == TMO) begin
                        // Abandon the operation; the owner never sees a response.
                        err     <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_v2_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_v2_arb
//  Description : Directed self-checking bench for aes_v2_arb with a
//                behavioural 4-cycle AES unit stub.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_v2_arb;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 15;

    logic               g_clk     = 1'b0;
    logic               g_resetn  = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_sub   = '0;
    logic [NREQ-1:0]    req_enc   = '0;
    logic [32*NREQ-1:0] req_rs1   = '0;
    logic [32*NREQ-1:0] req_rs2   = '0;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    resp_valid;
    logic [31:0]        resp_rd;
    logic               busy;
    logic               err;
    logic               aes_valid;
    logic               aes_sub;
    logic               aes_enc;
    logic [31:0]        aes_rs1;
    logic [31:0]        aes_rs2;
    logic               aes_ready;
    logic [31:0]        aes_rd;

    int checks = 0;
    int errors = 0;

    logic        stub_en     = 1'b1;
    logic        force_ready = 1'b0;
    int          stage       = 0;
    logic [31:0] st_rs1      = '0;
    logic [31:0] st_rs2      = '0;

    aes_v2_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .req_valid  (req_valid),
        .req_sub    (req_sub),
        .req_enc    (req_enc),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_ack    (req_ack),
        .resp_valid (resp_valid),
        .resp_rd    (resp_rd),
        .busy       (busy),
        .err        (err),
        .aes_valid  (aes_valid),
        .aes_sub    (aes_sub),
        .aes_enc    (aes_enc),
        .aes_rs1    (aes_rs1),
        .aes_rs2    (aes_rs2),
        .aes_ready  (aes_ready),
        .aes_rd     (aes_rd)
    );

    always #5 g_clk = ~g_clk;

    // ---------------- GF(2^8) helpers for the unit model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gm(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] unit_fn(input logic sub, input logic enc, input logic [31:0] x);
        logic [7:0] a0, a1, a2, a3;
        a0 = x[7:0]; a1 = x[15:8]; a2 = x[23:16]; a3 = x[31:24];
        if (sub) begin
            if (enc) return {sbox(a3), sbox(a2), sbox(a1), sbox(a0)};
            else     return {isbox(a3), isbox(a2), isbox(a1), isbox(a0)};
        end else if (enc) begin
            return {gm(a0,8'd3)^a1^a2^gm(a3,8'd2),
                    a0^a1^gm(a2,8'd2)^gm(a3,8'd3),
                    a0^gm(a1,8'd2)^gm(a2,8'd3)^a3,
                    gm(a0,8'd2)^gm(a1,8'd3)^a2^a3};
        end else begin
            return {gm(a0,8'd11)^gm(a1,8'd13)^gm(a2,8'd9)^gm(a3,8'd14),
                    gm(a0,8'd13)^gm(a1,8'd9)^gm(a2,8'd14)^gm(a3,8'd11),
                    gm(a0,8'd9)^gm(a1,8'd14)^gm(a2,8'd11)^gm(a3,8'd13),
                    gm(a0,8'd14)^gm(a1,8'd11)^gm(a2,8'd13)^gm(a3,8'd9)};
        end
    endfunction

    // Unit stub: start sampled at the grant edge, result driven three cycles later.
    assign aes_ready = (stub_en && stage == 3) || force_ready;
    assign aes_rd    = unit_fn(aes_sub, aes_enc, aes_rs1);

    // Unit stub sequencing; the unit sees its operands every cycle, so they must not move.
    always @(posedge g_clk) begin
        if (!g_resetn) begin
            stage <= 0;
        end else begin
            if (stage >= 1 && stage <= 3) begin
                checks++;
                if (aes_rs1 !== st_rs1 || aes_rs2 !== st_rs2) begin
                    errors++;
                    $display("FAIL operand_stable: got %h/%h required %h/%h", aes_rs1, aes_rs2, st_rs1, st_rs2);
                end
            end
            if (aes_valid) begin
                stage  <= 1;
                st_rs1 <= aes_rs1;
                st_rs2 <= aes_rs2;
            end else if (stage == 1 || stage == 2) begin
                stage <= stage + 1;
            end else begin
                stage <= 0;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic apply_reset();
        @(negedge g_clk);
        g_resetn  = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
    endtask

    task automatic run_single(input int idx, input logic sub, input logic enc,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] exp_rd, input logic scramble, input string name);
        logic [NREQ-1:0] onehot;
        onehot = NREQ'(1) << idx;
        @(negedge g_clk);
        req_valid[idx]           = 1'b1;
        req_sub[idx]             = sub;
        req_enc[idx]             = enc;
        req_rs1[32*idx +: 32]    = rs1;
        req_rs2[32*idx +: 32]    = rs2;
        #1;
        checks++;
        if (req_ack !== onehot || aes_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_ack: got ack=%b valid=%b required ack=%b valid=1", name, req_ack, aes_valid, onehot);
        end
        @(negedge g_clk);
        req_valid[idx] = 1'b0;
        if (scramble) begin
            req_rs1[32*idx +: 32] = $urandom;
            req_rs2[32*idx +: 32] = $urandom;
            req_sub[idx]          = ~sub;
            req_enc[idx]          = ~enc;
        end
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge g_clk);
            #1;
            if (k < 4) begin
                checks++;
                if (resp_valid !== '0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy_c%0d: got resp_valid=%b busy=%b required 0/1", name, k, resp_valid, busy);
                end
            end else begin
                checks++;
                if (resp_valid !== onehot || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_resp_valid: got %b busy=%b required %b busy=0", name, resp_valid, busy, onehot);
                end
                checks++;
                if (resp_rd !== exp_rd) begin
                    errors++;
                    $display("FAIL %s_resp_rd: got %h required %h", name, resp_rd, exp_rd);
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge g_clk);
        g_resetn  = 1'b0;
        req_valid = 2'b11;
        @(negedge g_clk);
        #1;
        checks++;
        if (req_ack !== 2'b00 || aes_valid !== 1'b0 || resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_handshake: got ack=%b aes_valid=%b resp_valid=%b required 00/0/00", req_ack, aes_valid, resp_valid);
        end
        checks++;
        if (resp_rd !== 32'h0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rd=%h busy=%b err=%b required 0/0/0", resp_rd, busy, err);
        end
        req_valid = '0;
        @(negedge g_clk);
        g_resetn = 1'b1;
    endtask

    task automatic test_single_sub();
        run_single(0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h6363_6363, 1'b0, "sub_enc");
    endtask

    task automatic test_inverse_and_mix();
        run_single(1, 1'b1, 1'b0, 32'h6363_6363, 32'h6363_6363, 32'h0000_0000, 1'b0, "sub_dec");
        run_single(1, 1'b0, 1'b1, 32'h0101_0101, 32'h0101_0101, 32'h0101_0101, 1'b0, "mix_enc");
    endtask

    task automatic test_operand_hold();
        run_single(0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h6363_6363, 1'b1, "hold");
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] exp_ack;
        logic [NREQ-1:0] exp_resp;
        logic [31:0]     exp_rd;
        int              other;
        apply_reset();
        req_valid      = 2'b11;
        req_sub        = 2'b11;
        req_enc        = 2'b11;
        req_rs1        = {32'h0101_0101, 32'h0000_0000};
        req_rs2        = {32'h0101_0101, 32'h0000_0000};
        for (int g = 0; g < 4; g++) begin
            if (g > 0) @(negedge g_clk);
            #1;
            exp_ack = (g % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ack !== exp_ack) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b required %b", g, req_ack, exp_ack);
            end
            if (g > 0) begin
                exp_resp = (g % 2 == 1) ? 2'b01 : 2'b10;
                exp_rd   = (g % 2 == 1) ? 32'h6363_6363 : 32'h7c7c_7c7c;
                checks++;
                if (resp_valid !== exp_resp || resp_rd !== exp_rd) begin
                    errors++;
                    $display("FAIL rr_resp%0d: got %b/%h required %b/%h", g, resp_valid, resp_rd, exp_resp, exp_rd);
                end
            end
            other = 1 - (g % 2);
            for (int k = 1; k <= 3; k++) begin
                @(negedge g_clk);
                if (k == 1) req_rs1[32*other +: 32] = $urandom;
                if (k == 3) req_rs1[32*other +: 32] = (other == 0) ? 32'h0000_0000 : 32'h0101_0101;
                if (g == 3 && k == 3) req_valid = 2'b00;
                #1;
                checks++;
                if (req_ack !== 2'b00) begin
                    errors++;
                    $display("FAIL rr_no_grant_busy%0d_%0d: got %b required 00", g, k, req_ack);
                end
            end
        end
        @(negedge g_clk);
        #1;
        checks++;
        if (resp_valid !== 2'b10 || resp_rd !== 32'h7c7c_7c7c) begin
            errors++;
            $display("FAIL rr_last_resp: got %b/%h required 10/7c7c7c7c", resp_valid, resp_rd);
        end
    endtask

    task automatic test_timeout();
        stub_en = 1'b0;
        @(negedge g_clk);
        req_valid[0]      = 1'b1;
        req_sub[0]        = 1'b1;
        req_enc[0]        = 1'b1;
        req_rs1[31:0]     = 32'h0;
        req_rs2[31:0]     = 32'h0;
        #1;
        checks++;
        if (req_ack !== 2'b01) begin
            errors++;
            $display("FAIL tmo_ack: got %b required 01", req_ack);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge g_clk);
            if (k == 1) req_valid = 2'b00;
            #1;
            checks++;
            if (k <= TIMEOUT) begin
                if (busy !== 1'b1 || err !== 1'b0 || resp_valid !== 2'b00) begin
                    errors++;
                    $display("FAIL tmo_wait_c%0d: got busy=%b err=%b resp=%b required 1/0/00", k, busy, err, resp_valid);
                end
            end else begin
                if (busy !== 1'b0 || err !== 1'b1 || resp_valid !== 2'b00) begin
                    errors++;
                    $display("FAIL tmo_expire: got busy=%b err=%b resp=%b required 0/1/00", busy, err, resp_valid);
                end
            end
        end
        stub_en = 1'b1;
        run_single(1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h6363_6363, 1'b0, "after_tmo");
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_err_sticky: got %b required 1", err);
        end
    endtask

    task automatic test_proto_err();
        apply_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL proto_pre: got err=%b required 0", err);
        end
        @(negedge g_clk);
        force_ready = 1'b1;
        @(negedge g_clk);
        force_ready = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL proto_err: got err=%b busy=%b resp=%b required 1/0/00", err, busy, resp_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge g_clk);
        req_valid      = 2'b10;
        req_sub[1]     = 1'b1;
        req_enc[1]     = 1'b1;
        req_rs1[63:32] = 32'h0;
        req_rs2[63:32] = 32'h0;
        #1;
        checks++;
        if (req_ack !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_ack: got %b required 10", req_ack);
        end
        @(negedge g_clk);
        req_valid = 2'b00;
        @(negedge g_clk);
        g_resetn = 1'b0;
        @(negedge g_clk);
        #1;
        checks++;
        if (resp_valid !== 2'b00 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got resp=%b busy=%b err=%b required 00/0/0", resp_valid, busy, err);
        end
        g_resetn = 1'b1;
        @(negedge g_clk);
        #1;
        checks++;
        if (resp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_resp: got resp=%b busy=%b required 00/0", resp_valid, busy);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ack !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_first_grant: got %b required 01", req_ack);
        end
        @(negedge g_clk);
        req_valid = 2'b00;
        repeat (4) @(negedge g_clk);
    endtask

    initial begin
        test_reset();
        test_single_sub();
        test_inverse_and_mix();
        test_operand_hold();
        test_back_to_back();
        test_timeout();
        test_proto_err();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
